// File: rtl/irq_pending.sv
// irq_pending: sticky request collector feeding the priority encoder.
// Latches request events per line, masks them, and offers the highest-index
// eligible pending line on a valid/ready handshake. The accepted line is cleared.
// Optional feature: define IRQ_PENDING_EDGE_EN to turn rising edges of req
// (instead of levels) into events.

module irq_pending #(
  parameter int N = 8,
  parameter int K = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overrun,
  input  logic         overrun_clr
);

  // state | meaning
  // IDLE  | no offer; looks for a masked pending line to offer
  // OFFER | out_idx offered and held until out_ready
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [0:0]   state;
  logic [N-1:0] set;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [K-1:0] sel_idx;
  logic         accept;

`ifdef IRQ_PENDING_EDGE_EN
  logic [N-1:0] req_q;

  // Previous request levels; reset to 0 so a line already high at release counts as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= req;
  end

  assign set = req & ~req_q;
`else
  assign set = req;
`endif

  assign accept    = (state == OFFER) & out_ready;
  assign out_valid = (state == OFFER);
  assign cand      = pending & mask;

  // One-hot clear of the line being accepted this cycle.
  always_comb begin
    clr = '0;
    if (accept) clr[out_idx] = 1'b1;
  end

  // Highest set index of the candidate vector wins.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) sel_idx = K'(i);
    end
  end

  // Pending register and sticky overrun; a set beats a same-cycle clear in both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | set;
      if (|(set & pending & ~clr)) overrun <= 1'b1;
      else if (overrun_clr)        overrun <= 1'b0;
    end
  end

  // Offer FSM: capture the winner in IDLE, hold it stable until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      out_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            out_idx <= sel_idx;
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending.sv
// Testbench for irq_pending: randomized and directed stimulus against a
// behavioural reference model; accepted indices go through a scoreboard queue.

module tb_irq_pending;
  localparam int N = 8;
  localparam int K = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] out_idx;
  logic [N-1:0] pending;
  logic         overrun;
  logic         overrun_clr;

  int checks = 0;
  int errors = 0;

  irq_pending #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .pending(pending), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of pending lines, current offer, overrun flag.
  bit m_pend[N];
  bit m_prev[N];
  bit m_valid;
  int m_idx;
  bit m_ovr;
  int exp_q[$];

  function automatic logic [N-1:0] model_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_prev[i] = 0;
    end
    m_valid = 0;
    m_idx   = 0;
    m_ovr   = 0;
    exp_q.delete();
  endtask

  // Applies one clock edge to the model using the inputs that were held through it.
  task automatic model_advance();
    bit ev[N];
    bit acc;
    bit any_ovr;
    bit old_pend[N];
    int best;
    acc = m_valid && out_ready;
    any_ovr = 0;
    for (int i = 0; i < N; i++) begin
`ifdef IRQ_PENDING_EDGE_EN
      ev[i] = req[i] && !m_prev[i];
`else
      ev[i] = req[i];
`endif
      old_pend[i] = m_pend[i];
      if (ev[i] && m_pend[i] && !(acc && i == m_idx)) any_ovr = 1;
    end
    if (any_ovr) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    for (int i = 0; i < N; i++) begin
      if (ev[i]) m_pend[i] = 1;
      else if (acc && i == m_idx) m_pend[i] = 0;
      m_prev[i] = req[i];
    end
    if (m_valid) begin
      if (acc) m_valid = 0;
    end else begin
      best = -1;
      for (int i = N - 1; i >= 0; i--) begin
        if (old_pend[i] && mask[i]) begin
          best = i;
          break;
        end
      end
      if (best >= 0) begin
        m_valid = 1;
        m_idx   = best;
      end
    end
  endtask

  // Drive one cycle of stimulus; predicted accepts go into the scoreboard queue.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] m,
                      input logic rdy, input logic oc);
    @(posedge clk);
    #1;
    if (!rst) model_advance();
    req = r;
    mask = m;
    out_ready = rdy;
    overrun_clr = oc;
    if (m_valid && rdy) exp_q.push_back(m_idx);
  endtask

  // Monitor: compare registered outputs with the model and pop on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (out_valid !== m_valid) begin
        errors++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
      end
      checks++;
      if (pending !== model_pend_vec()) begin
        errors++;
        $display("FAIL pending: got %h expected %h at %0t", pending, model_pend_vec(), $time);
      end
      checks++;
      if (overrun !== m_ovr) begin
        errors++;
        $display("FAIL overrun: got %b expected %b at %0t", overrun, m_ovr, $time);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL grant: got idx %0d but no grant expected at %0t", out_idx, $time);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (int'(out_idx) != e) begin
            errors++;
            $display("FAIL grant: got idx %0d expected %0d at %0t", out_idx, e, $time);
          end
        end
      end else if (out_valid && m_valid) begin
        checks++;
        if (int'(out_idx) != m_idx) begin
          errors++;
          $display("FAIL offer_idx: got %0d expected %0d at %0t", out_idx, m_idx, $time);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    rst = 1'b1;
    req = '0;
    mask = '0;
    out_ready = 1'b0;
    overrun_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single pulse on line 2, ready held high.
    step(8'h04, 8'hFF, 1'b1, 1'b0);
    repeat (5) step(8'h00, 8'hFF, 1'b1, 1'b0);

    // Priority: 7 held while 6 arrives, then 7, 6, 0 in order.
    step(8'h81, 8'hFF, 1'b0, 1'b0);
    repeat (3) step(8'h00, 8'hFF, 1'b0, 1'b0);
    step(8'h40, 8'hFF, 1'b0, 1'b0);
    repeat (3) step(8'h00, 8'hFF, 1'b0, 1'b0);
    repeat (8) step(8'h00, 8'hFF, 1'b1, 1'b0);

    // Mask: pending 4 and 5, only 4 eligible, then unmask 5.
    step(8'h30, 8'h10, 1'b1, 1'b0);
    repeat (6) step(8'h00, 8'h10, 1'b1, 1'b0);
    repeat (4) step(8'h00, 8'h30, 1'b1, 1'b0);

    // Overrun: line 3 pulsed twice before accept, held until cleared.
    step(8'h08, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0);
    step(8'h08, 8'hFF, 1'b0, 1'b0);
    repeat (3) step(8'h00, 8'hFF, 1'b0, 1'b0);
    repeat (3) step(8'h00, 8'hFF, 1'b1, 1'b0);
    step(8'h00, 8'hFF, 1'b1, 1'b1);
    repeat (2) step(8'h00, 8'hFF, 1'b1, 1'b0);

    // Collision: line 3 re-requested in the cycle of its accept.
    step(8'h08, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0);
    step(8'h08, 8'hFF, 1'b1, 1'b0);
    repeat (5) step(8'h00, 8'hFF, 1'b1, 1'b1);

    // Held level on line 1 for 10 cycles.
    repeat (10) step(8'h02, 8'hFF, 1'b1, 1'b0);
    repeat (4) step(8'h00, 8'hFF, 1'b1, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step(r, ($urandom_range(0, 3) == 0) ? N'($urandom) : '1,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of an offer with everything pending.
    repeat (3) step(8'hFF, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    req = '0;
    out_ready = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++;
    if (pending !== '0) begin errors++; $display("FAIL rst_pending: got %h expected 00", pending); end
    checks++;
    if (out_idx !== '0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", out_idx); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step(8'h00, 8'hFF, 1'b1, 1'b0);
    step(8'h20, 8'hFF, 1'b1, 1'b0);
    repeat (5) step(8'h00, 8'hFF, 1'b1, 1'b0);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL grants_outstanding: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
